// File: rtl/fir_pkg.sv
// Shared constants, loader state encoding and index-width helper for the FIR coefficient loader.
package fir_pkg;

  localparam int TAPS_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } loader_state_e;

  // Index width that stays at least one bit for a single-tap build.
  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register arrays; the active bank is replaced
// in one edge by the commit strobe so the filter never sees a partial update.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS       = TAPS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_W      = idx_width(TAPS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             commit,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]  active
);

  logic [TAPS-1:0][DATA_WIDTH-1:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Streams TAPS coefficient words into a shadow bank and commits them atomically.
// Optional registered readback port enabled by FIR_COEF_LOADER_READBACK_EN.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int TAPS       = TAPS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int IDX_W     = idx_width(TAPS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_last,
  output logic [TAPS-1:0][DATA_WIDTH-1:0]  w_N,
  output logic                             coef_update,
  output logic                             load_err,
  output logic                             busy
`ifdef FIR_COEF_LOADER_READBACK_EN
  ,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  loader_state_e state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic accept, at_last, wr_en, commit, err_set;

  assign accept  = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (accept && at_last) begin
          state_nxt = s_last ? COMMIT : DRAIN;
        end
      end
      COMMIT: state_nxt = LOAD;
      DRAIN: begin
        if (accept && s_last) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // A short sequence and an over-long one are both malformed: exactly one of
  // "last word" and "last index" is true at the accepting edge.
  always_comb begin
    s_ready = !rst && (state != COMMIT);
    wr_en   = accept && (state == LOAD);
    commit  = (state == COMMIT);
    err_set = wr_en && (s_last ^ at_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      load_err    <= 1'b0;
      coef_update <= 1'b0;
    end else begin
      load_err    <= err_set;
      coef_update <= commit;
      if (wr_en) begin
        idx <= (s_last || at_last) ? '0 : idx + 1'b1;
      end
    end
  end

  assign busy = (idx != '0) || (state != LOAD);

  fir_coef_bank #(
    .TAPS       (TAPS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (s_data),
    .commit  (commit),
    .active  (w_N)
  );

`ifdef FIR_COEF_LOADER_READBACK_EN
  // Samples the active bank before any commit on the same edge lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= (32'(rd_idx) < TAPS) ? w_N[rd_idx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a scoreboard of expected coefficient banks.
module tb_fir_coef_loader;
  import fir_pkg::*;

  localparam int TAPS = 4;
  localparam int DW   = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     s_valid;
  logic                     s_ready;
  logic [DW-1:0]            s_data;
  logic                     s_last;
  logic [TAPS-1:0][DW-1:0]  w_N;
  logic                     coef_update;
  logic                     load_err;
  logic                     busy;
`ifdef FIR_COEF_LOADER_READBACK_EN
  logic [1:0]               rd_idx;
  logic [DW-1:0]            rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int n_upd  = 0;
  int n_err  = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  fir_coef_loader #(.TAPS(TAPS), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .w_N         (w_N),
    .coef_update (coef_update),
    .load_err    (load_err),
    .busy        (busy)
`ifdef FIR_COEF_LOADER_READBACK_EN
    ,
    .rd_idx      (rd_idx),
    .rd_data     (rd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l, output int waits);
    waits   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && waits < 16) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 16) check("ready_timeout", 64'(waits), 64'd0);
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (load_err === 1'b1) n_err++;
      if (coef_update === 1'b1) begin
        n_upd++;
        check("sb_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) check("bank", w_N, sb.pop_front());
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
`ifdef FIR_COEF_LOADER_READBACK_EN
    rd_idx = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_w", w_N, 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_flags", 64'({coef_update, load_err, busy}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'd1);

    // Basic load 1,2,3,4
    sb.push_back({16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = 1; i <= 4; i++) send(DW'(i), (i == 4), w);
    idle();
    check("commit_ready", 64'(s_ready), 64'd0);
    check("commit_busy", 64'(busy), 64'd1);
    check("commit_w_old", w_N, 64'd0);
    check("commit_upd_low", 64'(coef_update), 64'd0);
    @(negedge clk);
    check("load1_w", w_N, {16'd4, 16'd3, 16'd2, 16'd1});
    check("load1_upd", 64'(coef_update), 64'd1);
    check("load1_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("load1_upd_pulse", 64'(coef_update), 64'd0);

    // Short sequence 5,6 then a good 9,8,7,6
    send(16'd5, 1'b0, w);
    send(16'd6, 1'b1, w);
    idle();
    check("short_err", 64'(load_err), 64'd1);
    check("short_busy", 64'(busy), 64'd0);
    check("short_w", w_N, {16'd4, 16'd3, 16'd2, 16'd1});
    @(negedge clk);
    check("short_err_pulse", 64'(load_err), 64'd0);
    sb.push_back({16'd6, 16'd7, 16'd8, 16'd9});
    send(16'd9, 1'b0, w);
    send(16'd8, 1'b0, w);
    send(16'd7, 1'b0, w);
    send(16'd6, 1'b1, w);
    idle();
    repeat (2) @(negedge clk);
    check("load2_w", w_N, {16'd6, 16'd7, 16'd8, 16'd9});

    // Long sequence 1..6: error after 4th, drain 5 and 6
    for (int i = 1; i <= 6; i++) begin
      send(DW'(i), (i == 6), w);
      if (i == 4) begin
        check("long_err", 64'(load_err), 64'd1);
        check("long_busy_drain", 64'(busy), 64'd1);
      end
    end
    idle();
    check("long_busy_end", 64'(busy), 64'd0);
    check("long_no_err", 64'(load_err), 64'd0);
    check("long_w", w_N, {16'd6, 16'd7, 16'd8, 16'd9});
    check("long_ready", 64'(s_ready), 64'd1);
    repeat (2) @(negedge clk);
    check("long_no_upd", 64'(n_upd), 64'd2);

    // Back-to-back sequences with s_valid held high
    sb.push_back({16'h14, 16'h13, 16'h12, 16'h11});
    sb.push_back({16'h24, 16'h23, 16'h22, 16'h21});
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        send(DW'(16'h11 + 16 * s + i), (i == 3), w);
        check("b2b_stall", 64'(w), (s == 1 && i == 0) ? 64'd1 : 64'd0);
      end
    end
    idle();
    repeat (3) @(negedge clk);
    check("b2b_w", w_N, {16'h24, 16'h23, 16'h22, 16'h21});
    check("b2b_upd", 64'(n_upd), 64'd4);

    // Reset mid-sequence
    send(16'hA1, 1'b0, w);
    send(16'hA2, 1'b0, w);
    idle();
    rst = 1'b1;
    #1;
    check("mrst_w", w_N, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("mrst_pulses", 64'({coef_update, load_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back({16'hB4, 16'hB3, 16'hB2, 16'hB1});
    for (int i = 0; i < 4; i++) send(DW'(16'hB1 + i), (i == 3), w);
    idle();
    repeat (3) @(negedge clk);
    check("fresh_w", w_N, {16'hB4, 16'hB3, 16'hB2, 16'hB1});
    check("fresh_busy", 64'(busy), 64'd0);

`ifdef FIR_COEF_LOADER_READBACK_EN
    rd_idx = 2'd2;
    @(negedge clk);
    check("rd_idx2", 64'(rd_data), 64'hB3);
    rd_idx = 2'd0;
    @(negedge clk);
    check("rd_idx0", 64'(rd_data), 64'hB1);
`endif

    repeat (3) @(negedge clk);
    check("total_updates", 64'(n_upd), 64'd5);
    check("total_errs", 64'(n_err), 64'd2);
    check("sb_left", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
